// File: rtl/acc_core.sv
// acc_core: ACC-family CPU core with a fetch/execute FSM, G/S/A registers,
// a synchronous external memory port and a sticky overflow flag.
// Instruction set: TCF, CA, CS, AD, TS; every other opcode is a NOP.
// Build option: define ACC_ONESCOMP_EN to make AD a ones' complement add
// with end-around carry. Leave it undefined for a two's complement add.
module acc_core #(
  parameter int          AW        = 12,
  parameter int          WW        = 15,
  parameter logic [AW-1:0] BOOT_ADDR = 'h800,
  parameter logic [WW-1:0] A_INIT    = 'h0055
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          step,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [WW:0]   mem_rdata,
  output logic          mem_wr,
  output logic [WW:0]   mem_wdata,
  output logic [WW-1:0] a_reg,
  output logic [AW-1:0] pc,
  output logic          ovf,
  output logic          idle,
  output logic          done
);

  typedef enum logic [2:0] {
    ST_WAIT      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_READ_INST = 3'd2,
    ST_EXEC0     = 3'd3,
    ST_EXEC1     = 3'd4
  } state_t;

  localparam logic [2:0] OP_TCF = 3'b001;
  localparam logic [2:0] OP_CA  = 3'b011;
  localparam logic [2:0] OP_CS  = 3'b100;
  localparam logic [2:0] OP_TS  = 3'b101;
  localparam logic [2:0] OP_AD  = 3'b110;

  state_t        state_reg, state_next;
  logic [AW-1:0] s_reg, s_next;
  logic [WW-1:0] g_reg, g_next;
  logic [WW-1:0] acc_reg, acc_next;
  logic          ovf_reg, ovf_next;
  logic          done_reg, done_next;
  logic          rd_raw, wr_raw;

  // Instruction fields: opcode in the top three bits, address in the low AW.
  logic [2:0]    opcode;
  logic [AW-1:0] dir;
  logic [WW-1:0] operand;
  assign opcode  = g_reg[WW-1:WW-3];
  assign dir     = g_reg[AW-1:0];
  assign operand = mem_rdata[WW-1:0];

  // The parity bit carries no meaning for the core.
  logic unused_parity;
  assign unused_parity = mem_rdata[WW];

  // AD adder: full-width sum with the carry kept so the ones' complement
  // build can fold it back in. The folded add can never carry again.
  logic [WW:0]   sum_full;
  logic [WW-1:0] add_result;
  logic          add_ovf;
  assign sum_full = {1'b0, acc_reg} + {1'b0, operand};
`ifdef ACC_ONESCOMP_EN
  assign add_result = sum_full[WW-1:0] + {{(WW-1){1'b0}}, sum_full[WW]};
`else
  assign add_result = sum_full[WW-1:0];
`endif
  // Overflow: like-signed operands producing a result of the other sign.
  assign add_ovf = (acc_reg[WW-1] == operand[WW-1]) &&
                   (add_result[WW-1] != acc_reg[WW-1]);

  // State and datapath registers; reset restores the boot context.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= ST_WAIT;
      s_reg     <= BOOT_ADDR;
      g_reg     <= '0;
      acc_reg   <= A_INIT;
      ovf_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      g_reg     <= g_next;
      acc_reg   <= acc_next;
      ovf_reg   <= ovf_next;
      done_reg  <= done_next;
    end
  end

  // Next-state, datapath updates and memory strobes for each FSM state.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    g_next     = g_reg;
    acc_next   = acc_reg;
    ovf_next   = ovf_reg;
    mem_addr   = s_reg;
    rd_raw     = 1'b0;
    wr_raw     = 1'b0;
    unique case (state_reg)
      ST_WAIT: begin
        if (step) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_addr   = s_reg;
        rd_raw     = 1'b1;
        state_next = ST_READ_INST;
      end
      ST_READ_INST: begin
        g_next     = mem_rdata[WW-1:0];
        s_next     = s_reg + 1'b1;
        state_next = ST_EXEC0;
      end
      ST_EXEC0: begin
        state_next = ST_WAIT;
        case (opcode)
          OP_TCF: s_next = dir;
          OP_CA, OP_CS, OP_AD: begin
            mem_addr   = dir;
            rd_raw     = 1'b1;
            state_next = ST_EXEC1;
          end
          OP_TS: begin
            mem_addr = dir;
            wr_raw   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_EXEC1: begin
        state_next = ST_WAIT;
        case (opcode)
          OP_CA: acc_next = operand;
          OP_CS: acc_next = ~operand;
          OP_AD: begin
            acc_next = add_result;
            ovf_next = ovf_reg | add_ovf;
          end
          default: ;
        endcase
      end
      default: state_next = ST_WAIT;
    endcase
  end

  // done fires in the first WAIT cycle after any instruction finishes.
  always_comb begin
    done_next = (state_reg != ST_WAIT) && (state_next == ST_WAIT);
  end

  // Strobes are gated by reset so an aborted instruction never writes.
  assign mem_rd    = rd_raw & rstn;
  assign mem_wr    = wr_raw & rstn;
  assign mem_wdata = {1'b0, acc_reg};
  assign a_reg     = acc_reg;
  assign pc        = s_reg;
  assign ovf       = ovf_reg;
  assign idle      = (state_reg == ST_WAIT);
  assign done      = done_reg;

endmodule

// File: tb/tb_acc_core.sv
// Directed bench for acc_core with a behavioural synchronous memory.
module tb_acc_core;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        step = 1'b0;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata = '0;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic [14:0] a_reg;
  logic [11:0] pc;
  logic        ovf;
  logic        idle;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem [0:4095];
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [11:0] last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;
  logic [11:0] rd_log [$];

  acc_core dut (
    .clk(clk), .rstn(rstn), .step(step),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .a_reg(a_reg), .pc(pc), .ovf(ovf), .idle(idle), .done(done)
  );

  always #5 clk = ~clk;

  // Memory model: registered read, writes only logged.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr];
      rd_log.push_back(mem_addr);
    end
    if (mem_wr) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= mem_addr;
      last_wr_data <= mem_wdata;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    step = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // One step pulse, then count negedges until done (bounded).
  task automatic run_instr(output int lat);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat;
  int wr_base;
  int done_base;
  logic [14:0] ad_exp;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
`ifdef ACC_ONESCOMP_EN
    ad_exp = 15'h0002;
`else
    ad_exp = 15'h0001;
`endif

    // Reset state
    do_reset();
    check("rst_pc", pc, 12'h800);
    check("rst_a", a_reg, 15'h0055);
    check("rst_ovf", ovf, 0);
    check("rst_idle", idle, 1);
    check("rst_done", done, 0);
    check("rst_strobes", {mem_rd, mem_wr}, 0);

    // CA 805 from boot
    mem[12'h800] = 16'h3805;
    mem[12'h805] = 16'h0123;
    rd_log.delete();
    done_base = done_cnt;
    run_instr(lat);
    check("ca_lat", lat, 5);
    @(negedge clk);
    check("ca_done_once", done, 0);
    check("ca_a", a_reg, 15'h0123);
    check("ca_pc", pc, 12'h801);
    check("ca_rd_cnt", rd_log.size(), 2);
    if (rd_log.size() == 2) begin
      check("ca_rd0", rd_log[0], 12'h800);
      check("ca_rd1", rd_log[1], 12'h805);
    end
    check("ca_done_cnt", done_cnt - done_base, 1);

    // TCF loop
    do_reset();
    mem[12'h800] = 16'h1800;
    wr_base = wr_cnt;
    for (int k = 0; k < 3; k++) begin
      run_instr(lat);
      check("tcf_lat", lat, 4);
      check("tcf_pc", pc, 12'h800);
    end
    check("tcf_no_wr", wr_cnt - wr_base, 0);

    // CA 3 then AD 7FFE
    do_reset();
    mem[12'h800] = 16'h3810; mem[12'h810] = 16'h0003;
    mem[12'h801] = 16'h6811; mem[12'h811] = 16'h7FFE;
    run_instr(lat);
    run_instr(lat);
    check("ad1_lat", lat, 5);
    check("ad1_a", a_reg, ad_exp);
    check("ad1_ovf", ovf, 0);

    // CA 3FFF, AD 1 -> overflow; TS; later CA keeps ovf
    mem[12'h802] = 16'h3812; mem[12'h812] = 16'h3FFF;
    mem[12'h803] = 16'h6813; mem[12'h813] = 16'h0001;
    mem[12'h804] = 16'h5010;
    mem[12'h805] = 16'h3814; mem[12'h814] = 16'h1234;
    run_instr(lat);
    run_instr(lat);
    check("ad2_a", a_reg, 15'h4000);
    check("ad2_ovf", ovf, 1);
    wr_base = wr_cnt;
    run_instr(lat);
    check("ts_lat", lat, 4);
    check("ts_wr_cnt", wr_cnt - wr_base, 1);
    check("ts_addr", last_wr_addr, 12'h010);
    check("ts_data", last_wr_data, 16'h4000);
    run_instr(lat);
    check("ca2_a", a_reg, 15'h1234);
    check("ovf_sticky", ovf, 1);

    // CS 0, then NOP with parity bit set
    mem[12'h806] = 16'h4815; mem[12'h815] = 16'h0000;
    mem[12'h807] = 16'h8123;
    run_instr(lat);
    check("cs_a", a_reg, 15'h7FFF);
    run_instr(lat);
    check("nop_lat", lat, 4);
    check("nop_a", a_reg, 15'h7FFF);
    check("nop_pc", pc, 12'h808);

    // Reset during EXEC0 of TS aborts the write
    mem[12'h808] = 16'h5020;
    wr_base = wr_cnt;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("abort_no_wr", wr_cnt - wr_base, 0);
    check("abort_pc", pc, 12'h800);
    check("abort_a", a_reg, 15'h0055);
    check("abort_ovf", ovf, 0);
    check("abort_idle", idle, 1);

    // Step during FETCH is ignored
    mem[12'h800] = 16'h1800;
    done_base = done_cnt;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (8) @(negedge clk);
    check("fetch_step_done", done_cnt - done_base, 1);
    check("fetch_step_idle", idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
